mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the valid/ready memory bus driven by the testbench BFM clocking block. Accepts one read or write request at a time, inserts a programmable number of wait states, then acknowledges with a single-cycle `ready` pulse and, for reads, returns data on `rdata`. It is the memory model the bench drives, with storage, handshake FSM, abort handling and transaction counters.

## Interface

- `DEPTH`, 64, number of words.
- `WIDTH`, 16, data width in bits.
- `ADDR_WIDTH`, $clog2(DEPTH), address width.
- `WAIT_STATES`, 2, wait cycles between request capture and ACK (0–15).
- `clk_i`  input  1  clock; all logic on rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `valid`  input  1  request valid from initiator.
- `wr_rd`  input  1  1 = write, 0 = read.
- `addr`  input  ADDR_WIDTH  word address.
- `wdata`  input  WIDTH  write data.
- `ready`  output  1  one-cycle acknowledge.
- `rdata`  output  WIDTH  read data, valid while `ready`=1 for a read.
- `err`  output  1  asserted with `ready` when the captured address ≥ DEPTH.
- `wr_count`  output  16  completed writes, saturating.
- `rd_count`  output  16  completed reads, saturating.

## Operation

- Reset (`rst_i`=0, asynchronous): FSM→IDLE; `ready`=0, `rdata`=0, `err`=0, counters=0, wait counter=0, every memory word=0. Reset mid-transaction discards the request with no write and no ACK.
- FSM states: IDLE, WAIT, ACK.
- IDLE: when `valid`=1 at an edge, capture `wr_rd`, `addr`, `wdata` into request registers. If WAIT_STATES=0, go to ACK; otherwise load the wait counter with WAIT_STATES and go to WAIT.
- WAIT: decrement the counter at each edge while `valid`=1. On the edge where the counter is 1, go to ACK. If `valid`=0 at any WAIT edge, abort: go to IDLE, no write, no counter change, no `ready`.
- Entering ACK, using captured values:
  - In-range write: mem[addr] ← wdata, `wr_count`+1.
  - In-range read: `rdata` ← mem[addr], `rd_count`+1.
  - Out-of-range address: `err`=1, no memory write, `rdata` ← 0, counters unchanged.
- ACK: `ready`=1 for exactly one cycle, then go to IDLE unconditionally. `err` clears together with `ready`.
- `rdata` holds its value until the next read ACK. Writes do not change `rdata`.
- Counters saturate at 16'hFFFF.
- Input changes after capture, other than `valid`, are ignored.
- Read-after-write to the same address in consecutive transactions returns the new data.

## Timing

- Request sampled at edge E0 (IDLE, `valid`=1). `ready`, `rdata` and `err` are registered and rise at edge E0+WAIT_STATES. They fall at E0+WAIT_STATES+1. The initiator samples `ready`=1 at E0+WAIT_STATES+1.
- Memory write takes effect at edge E0+WAIT_STATES.
- The initiator updates outputs after the edge at which it sees `ready`, so at the edge ending ACK it still holds the old request. The responder is in ACK at that edge and ignores it. The next IDLE edge samples the new request.
- Back-to-back throughput: one transaction per WAIT_STATES+2 cycles.
- `valid` low in IDLE: no state change, all outputs stable.

## Test plan

- Reset: hold `rst_i`=0 mid-WAIT, release → `ready`=0, `rdata`=0, counters=0; a read of addr 5 returns 16'h0000.
- Write/read, WAIT_STATES=2: write addr 10 ← 16'hA5A5, then read addr 10 → `ready` rises 2 cycles after capture, `rdata`=16'hA5A5, `wr_count`=1, `rd_count`=1.
- Multiple write/read: write addrs 0..63 with data addr*3, then read all back → every word matches, 64 `ready` pulses per phase, `wr_count`=`rd_count`=64.
- Abort: assert read `valid`, drop it after 1 WAIT cycle → no `ready`, `rd_count` unchanged, FSM back in IDLE. A following write completes normally.
- WAIT_STATES=0, back-to-back write then read to addr 63 → `ready` on the cycle after each capture, with one IDLE cycle between transactions; `rdata` equals the written value.
- DEPTH=48: read addr 50 → `ready`=1 with `err`=1, `rdata`=0, counters unchanged. Write addr 50 leaves the memory unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for a valid/ready bus: a word-addressed store with a
// request FSM, programmable wait states, abort on dropped valid, and saturating counters.
`timescale 1ns/1ps
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WIDTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_wait_cnt_next;
  logic                  w_enter_ack;
  logic                  w_load_req;

  logic                  r_req_wr;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [WIDTH-1:0]      r_req_wdata;

  logic                  w_cur_wr;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [WIDTH-1:0]      w_cur_wdata;
  logic                  w_in_range;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic                  r_ready;
  logic [WIDTH-1:0]      r_rdata;
  logic                  r_err;
  logic [15:0]           r_wr_count;
  logic [15:0]           r_rd_count;

  // Next-state, wait-counter and ACK-entry decode.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_enter_ack     = 1'b0;
    w_load_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid) begin
          w_load_req = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next_state = ST_ACK;
            w_enter_ack  = 1'b1;
          end else begin
            w_next_state    = ST_WAIT;
            w_wait_cnt_next = WAIT_INIT;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!valid) begin
          w_next_state    = ST_IDLE;
          w_wait_cnt_next = 4'd0;
        end else if (r_wait_cnt == 4'd1) begin
          w_next_state    = ST_ACK;
          w_enter_ack     = 1'b1;
          w_wait_cnt_next = 4'd0;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
      ST_ACK: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state    = ST_IDLE;
        w_wait_cnt_next = 4'd0;
      end
    endcase
  end

  // With zero wait states ACK is entered on the capture edge, so the live inputs are used.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_cur_wr    = wr_rd;
      w_cur_addr  = addr;
      w_cur_wdata = wdata;
    end else begin
      w_cur_wr    = r_req_wr;
      w_cur_addr  = r_req_addr;
      w_cur_wdata = r_req_wdata;
    end
    w_in_range = ({1'b0, w_cur_addr} < DEPTH_L);
  end

  // FSM state and wait counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Request capture in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req_wr    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else if (w_load_req) begin
      r_req_wr    <= wr_rd;
      r_req_addr  <= addr;
      r_req_wdata <= wdata;
    end
  end

  // Storage: cleared on reset, written only by an in-range write entering ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enter_ack && w_cur_wr && w_in_range) begin
      r_mem[w_cur_addr] <= w_cur_wdata;
    end
  end

  // Registered acknowledge, read data, error flag and saturating counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_wr_count <= 16'd0;
      r_rd_count <= 16'd0;
    end else if (w_enter_ack) begin
      r_ready <= 1'b1;
      r_err   <= !w_in_range;
      if (!w_cur_wr) begin
        r_rdata <= w_in_range ? r_mem[w_cur_addr] : '0;
      end
      if (w_in_range && w_cur_wr && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_in_range && !w_cur_wr && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign ready    = r_ready;
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (2 wait states, 0 wait states,
// 48-word depth) compared against an array-based behavioural model.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        v_valid [3];
  logic        v_wr    [3];
  logic [5:0]  v_addr  [3];
  logic [15:0] v_wdata [3];
  logic        o_ready [3];
  logic [15:0] o_rdata [3];
  logic        o_err   [3];
  logic [15:0] o_wrc   [3];
  logic [15:0] o_rdc   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] m_mem [3][64];
  int          m_wr  [3];
  int          m_rd  [3];
  int          c_depth [3] = '{64, 64, 48};
  int          c_ws    [3] = '{2, 0, 2};

  mem_responder #(.DEPTH(64), .WIDTH(16), .WAIT_STATES(2)) u_ws2 (
    .clk_i(clk), .rst_i(rst_n), .valid(v_valid[0]), .wr_rd(v_wr[0]), .addr(v_addr[0]),
    .wdata(v_wdata[0]), .ready(o_ready[0]), .rdata(o_rdata[0]), .err(o_err[0]),
    .wr_count(o_wrc[0]), .rd_count(o_rdc[0]));

  mem_responder #(.DEPTH(64), .WIDTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst_n), .valid(v_valid[1]), .wr_rd(v_wr[1]), .addr(v_addr[1]),
    .wdata(v_wdata[1]), .ready(o_ready[1]), .rdata(o_rdata[1]), .err(o_err[1]),
    .wr_count(o_wrc[1]), .rd_count(o_rdc[1]));

  mem_responder #(.DEPTH(48), .WIDTH(16), .WAIT_STATES(2)) u_d48 (
    .clk_i(clk), .rst_i(rst_n), .valid(v_valid[2]), .wr_rd(v_wr[2]), .addr(v_addr[2]),
    .wdata(v_wdata[2]), .ready(o_ready[2]), .rdata(o_rdata[2]), .err(o_err[2]),
    .wr_count(o_wrc[2]), .rd_count(o_rdc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 64; a++) m_mem[d][a] = 16'h0000;
      m_wr[d] = 0;
      m_rd[d] = 0;
    end
  endfunction

  // Outcome of one completed transaction in memory-model terms.
  function automatic void model_apply(input int d, input bit wr, input int a,
                                      input logic [15:0] wd, output bit e_err,
                                      output logic [15:0] e_rdata);
    e_rdata = 16'h0000;
    if (a >= c_depth[d]) begin
      e_err = 1'b1;
    end else begin
      e_err = 1'b0;
      if (wr) begin
        m_mem[d][a] = wd;
        m_wr[d]++;
      end else begin
        e_rdata = m_mem[d][a];
        m_rd[d]++;
      end
    end
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that ends the ACK cycle.
  task automatic do_txn(input int d, input bit wr, input logic [5:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output logic er,
                        output logic aft, output int e0);
    v_valid[d] = 1'b1;
    v_wr[d]    = wr;
    v_addr[d]  = a;
    v_wdata[d] = wd;
    @(posedge clk);
    #1;
    e0  = cyc;
    lat = 0;
    while (o_ready[d] !== 1'b1 && lat < 40) begin
      v_wr[d]    = 1'($urandom_range(1, 0));
      v_addr[d]  = 6'($urandom_range(63, 0));
      v_wdata[d] = 16'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    rd = o_rdata[d];
    er = o_err[d];
    v_valid[d] = 1'b0;
    @(posedge clk);
    #1;
    aft = o_ready[d];
  endtask

  task automatic test_reset();
    int lat, e0;
    logic [15:0] rd;
    logic er, aft;
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (o_ready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, o_ready[d]); end
      n_checks++; if (o_rdata[d] !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0000", d, o_rdata[d]); end
      n_checks++; if (o_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", d, o_err[d]); end
      n_checks++; if (o_wrc[d] !== 16'd0 || o_rdc[d] !== 16'd0) begin n_fail++; $display("FAIL reset_counts[%0d]: got %0d/%0d expected 0/0", d, o_wrc[d], o_rdc[d]); end
    end
    // Write to addr 5 interrupted by reset while in WAIT.
    v_valid[0] = 1'b1; v_wr[0] = 1'b1; v_addr[0] = 6'd5; v_wdata[0] = 16'hBEEF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    v_valid[0] = 1'b0;
    #3;
    n_checks++; if (o_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midwait_reset_ready: got %b expected 0", o_ready[0]); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    n_checks++; if (o_ready[0] !== 1'b0 || o_rdata[0] !== 16'h0000) begin n_fail++; $display("FAIL midwait_reset_out: got ready=%b rdata=%h expected 0/0000", o_ready[0], o_rdata[0]); end
    n_checks++; if (o_wrc[0] !== 16'd0 || o_rdc[0] !== 16'd0) begin n_fail++; $display("FAIL midwait_reset_counts: got %0d/%0d expected 0/0", o_wrc[0], o_rdc[0]); end
    do_txn(0, 1'b0, 6'd5, 16'h0000, lat, rd, er, aft, e0);
    m_rd[0]++;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL reset_read_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_read_addr5: got %h expected 0000", rd); end
  endtask

  task automatic test_write_read();
    int lat, e0;
    logic [15:0] rd, erd;
    logic er, aft;
    bit eerr;
    model_apply(0, 1'b1, 10, 16'hA5A5, eerr, erd);
    do_txn(0, 1'b1, 6'd10, 16'hA5A5, lat, rd, er, aft, e0);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    n_checks++; if (aft !== 1'b0) begin n_fail++; $display("FAIL wr_ready_width: got %b expected 0", aft); end
    n_checks++; if (o_wrc[0] !== 16'(m_wr[0])) begin n_fail++; $display("FAIL wr_count: got %0d expected %0d", o_wrc[0], m_wr[0]); end
    model_apply(0, 1'b0, 10, 16'h0000, eerr, erd);
    do_txn(0, 1'b0, 6'd10, 16'h0000, lat, rd, er, aft, e0);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data: got %h expected a5a5", rd); end
    n_checks++; if (o_rdc[0] !== 16'(m_rd[0])) begin n_fail++; $display("FAIL rd_count: got %0d expected %0d", o_rdc[0], m_rd[0]); end
    model_apply(0, 1'b1, 11, 16'h1357, eerr, erd);
    do_txn(0, 1'b1, 6'd11, 16'h1357, lat, rd, er, aft, e0);
    n_checks++; if (o_rdata[0] !== 16'hA5A5) begin n_fail++; $display("FAIL rdata_hold: got %h expected a5a5", o_rdata[0]); end
  endtask

  task automatic test_fill();
    int lat, e0, pulses;
    logic [15:0] rd, erd;
    logic er, aft;
    bit eerr;
    pulses = 0;
    for (int a = 0; a < 64; a++) begin
      model_apply(0, 1'b1, a, 16'(a * 3), eerr, erd);
      do_txn(0, 1'b1, 6'(a), 16'(a * 3), lat, rd, er, aft, e0);
      if (lat == 2 && aft == 1'b0) pulses++;
    end
    n_checks++; if (pulses !== 64) begin n_fail++; $display("FAIL fill_write_pulses: got %0d expected 64", pulses); end
    pulses = 0;
    for (int a = 0; a < 64; a++) begin
      model_apply(0, 1'b0, a, 16'h0000, eerr, erd);
      do_txn(0, 1'b0, 6'(a), 16'h0000, lat, rd, er, aft, e0);
      if (lat == 2 && aft == 1'b0) pulses++;
      n_checks++; if (rd !== 16'(a * 3)) begin n_fail++; $display("FAIL fill_read[%0d]: got %h expected %h", a, rd, 16'(a * 3)); end
    end
    n_checks++; if (pulses !== 64) begin n_fail++; $display("FAIL fill_read_pulses: got %0d expected 64", pulses); end
    n_checks++; if (o_wrc[0] !== 16'(m_wr[0]) || o_rdc[0] !== 16'(m_rd[0])) begin n_fail++; $display("FAIL fill_counts: got %0d/%0d expected %0d/%0d", o_wrc[0], o_rdc[0], m_wr[0], m_rd[0]); end
  endtask

  task automatic test_abort();
    int lat, e0;
    logic [15:0] rd, erd;
    logic er, aft, seen;
    bit eerr;
    logic [15:0] wd;
    for (int k = 0; k < 2; k++) begin
      v_valid[0] = 1'b1; v_wr[0] = 1'b0; v_addr[0] = 6'd7;
      @(posedge clk);
      #1;
      for (int j = 0; j < k; j++) begin
        @(posedge clk);
        #1;
      end
      v_valid[0] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (o_ready[0] === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready[%0d]: got %b expected 0", k, seen); end
      n_checks++; if (o_rdc[0] !== 16'(m_rd[0])) begin n_fail++; $display("FAIL abort_rd_count[%0d]: got %0d expected %0d", k, o_rdc[0], m_rd[0]); end
      wd = 16'($urandom);
      model_apply(0, 1'b1, 7, wd, eerr, erd);
      do_txn(0, 1'b1, 6'd7, wd, lat, rd, er, aft, e0);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL abort_next_latency[%0d]: got %0d expected 2", k, lat); end
      n_checks++; if (o_wrc[0] !== 16'(m_wr[0])) begin n_fail++; $display("FAIL abort_next_wr_count[%0d]: got %0d expected %0d", k, o_wrc[0], m_wr[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat_w, lat_r, e0_w, e0_r;
    logic [15:0] rd, erd, wd;
    logic er, aft;
    bit eerr;
    for (int d = 0; d < 2; d++) begin
      wd = 16'($urandom);
      model_apply(d, 1'b1, 63, wd, eerr, erd);
      do_txn(d, 1'b1, 6'd63, wd, lat_w, rd, er, aft, e0_w);
      model_apply(d, 1'b0, 63, 16'h0000, eerr, erd);
      do_txn(d, 1'b0, 6'd63, 16'h0000, lat_r, rd, er, aft, e0_r);
      n_checks++; if (lat_w !== c_ws[d] || lat_r !== c_ws[d]) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d/%0d expected %0d", d, lat_w, lat_r, c_ws[d]); end
      n_checks++; if (e0_r - e0_w !== c_ws[d] + 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", d, e0_r - e0_w, c_ws[d] + 2); end
      n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", d, rd, erd); end
    end
  endtask

  task automatic test_out_of_range();
    int lat, e0;
    logic [15:0] rd, erd;
    logic er, aft;
    bit eerr;
    model_apply(2, 1'b1, 2, 16'h7777, eerr, erd);
    do_txn(2, 1'b1, 6'd2, 16'h7777, lat, rd, er, aft, e0);
    model_apply(2, 1'b0, 2, 16'h0000, eerr, erd);
    do_txn(2, 1'b0, 6'd2, 16'h0000, lat, rd, er, aft, e0);
    model_apply(2, 1'b0, 50, 16'h0000, eerr, erd);
    do_txn(2, 1'b0, 6'd50, 16'h0000, lat, rd, er, aft, e0);
    n_checks++; if (er !== 1'b1 || lat !== 2) begin n_fail++; $display("FAIL oor_read_err: got err=%b lat=%0d expected 1/2", er, lat); end
    n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL oor_read_rdata: got %h expected 0000", rd); end
    n_checks++; if (o_err[2] !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b expected 0", o_err[2]); end
    model_apply(2, 1'b1, 50, 16'h1234, eerr, erd);
    do_txn(2, 1'b1, 6'd50, 16'h1234, lat, rd, er, aft, e0);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_write_err: got %b expected 1", er); end
    n_checks++; if (o_wrc[2] !== 16'(m_wr[2]) || o_rdc[2] !== 16'(m_rd[2])) begin n_fail++; $display("FAIL oor_counts: got %0d/%0d expected %0d/%0d", o_wrc[2], o_rdc[2], m_wr[2], m_rd[2]); end
    for (int a = 0; a < 48; a++) begin
      model_apply(2, 1'b0, a, 16'h0000, eerr, erd);
      do_txn(2, 1'b0, 6'(a), 16'h0000, lat, rd, er, aft, e0);
      n_checks++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL oor_mem_intact[%0d]: got %h err=%b expected %h err=0", a, rd, er, erd); end
    end
  endtask

  task automatic test_random();
    int d, lat, e0;
    bit wr, eerr;
    logic [5:0] a;
    logic [15:0] wd, rd, erd;
    logic er, aft;
    for (int i = 0; i < 150; i++) begin
      d  = $urandom_range(2, 0);
      wr = 1'($urandom_range(1, 0));
      a  = 6'($urandom_range(63, 0));
      wd = 16'($urandom);
      model_apply(d, wr, int'(a), wd, eerr, erd);
      do_txn(d, wr, a, wd, lat, rd, er, aft, e0);
      n_checks++; if (lat !== c_ws[d]) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, c_ws[d]); end
      n_checks++; if (er !== eerr) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, er, eerr); end
      if (!wr) begin
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rd, erd); end
      end
      n_checks++; if (aft !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_width[%0d]: got %b expected 0", i, aft); end
      n_checks++; if (o_wrc[d] !== 16'(m_wr[d]) || o_rdc[d] !== 16'(m_rd[d])) begin n_fail++; $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", i, o_wrc[d], o_rdc[d], m_wr[d], m_rd[d]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      v_valid[d] = 1'b0; v_wr[d] = 1'b0; v_addr[d] = 6'd0; v_wdata[d] = 16'h0000;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_fill();
    test_abort();
    test_back_to_back();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
